// File: rtl/motor_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : motor_frame_pkg
//  Brief    : Shared constants, enums and CRC16 helper for the motor-bus
//             receive decoder (magic numbers, frame lengths, state encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package motor_frame_pkg;

  localparam logic [31:0] MAGIC_STATUS_REQUEST = 32'h1CE1_CEBB;
  localparam logic [31:0] MAGIC_SETPOINT       = 32'hD0D0_D0D0;
  localparam logic [31:0] MAGIC_CONTROL_MODE   = 32'hBAAD_A555;

  localparam int MAGIC_NUMBER_LENGTH   = 4;
  localparam int STATUS_REQUEST_LENGTH = 7;
  localparam int SETPOINT_LENGTH       = 10;
  localparam int CONTROL_MODE_LENGTH   = 29;
  localparam int MAX_FRAME_LENGTH      = 29;

  typedef enum logic [1:0] {
    FRAME_NONE           = 2'd0,
    FRAME_STATUS_REQUEST = 2'd1,
    FRAME_SETPOINT       = 2'd2,
    FRAME_CONTROL_MODE   = 2'd3
  } frame_type_e;

  typedef enum logic [1:0] {
    DEC_HUNT    = 2'd0,
    DEC_COLLECT = 2'd1,
    DEC_CHECK   = 2'd2
  } dec_state_e;

  // CRC16, poly 0x8005 (x^16+x^15+x^2+1), MSB of the data byte enters first.
  function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data,
                                               input logic [15:0] crc);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_accumulator
//  Brief    : Registered CRC16 accumulator. i_init loads 0xFFFF, i_en folds
//             one byte. i_init has priority over i_en.
//  Revision : 1.0 - initial release
// ============================================================================
module crc16_accumulator
  import motor_frame_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // CRC register: seed on frame start, fold each covered payload byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_crc <= '0;
    else if (i_init) r_crc <= 16'hFFFF;
    else if (i_en)   r_crc <= nextCRC16_D8(i_byte, r_crc);
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/motor_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : motor_frame_decoder
//  Brief    : RS485 motor-bus receive decoder. Hunts for the three master
//             frame magics, collects the payload, checks CRC16, filters on
//             my_id and presents committed fields with one-cycle strobes.
//             Optional statistics counters: MOTOR_FRAME_DECODER_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module motor_frame_decoder
  import motor_frame_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int BAUDRATE      = 2_000_000,
  parameter int TIMEOUT_BYTES = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic [7:0]         my_id,
  output logic               status_request,
  output logic               setpoint_valid,
  output logic signed [23:0] setpoint,
  output logic               control_mode_valid,
  output logic [7:0]         control_mode,
  output logic signed [15:0] Kp,
  output logic signed [15:0] Ki,
  output logic signed [15:0] Kd,
  output logic signed [23:0] PWMLimit,
  output logic signed [23:0] IntegralLimit,
  output logic signed [23:0] deadband,
  output logic signed [23:0] gearboxRatio,
  output logic [15:0]        crc_error_count,
  output logic [15:0]        timeout_count
);

  localparam int TMO_CYCLES  = CLK_FREQ_HZ / BAUDRATE * 10 * TIMEOUT_BYTES;
  localparam int TMO_W       = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam int PAYLOAD_MAX = MAX_FRAME_LENGTH - MAGIC_NUMBER_LENGTH;

  localparam logic [4:0] LEN_STATUS  = 5'(STATUS_REQUEST_LENGTH - MAGIC_NUMBER_LENGTH);
  localparam logic [4:0] LEN_SETPNT  = 5'(SETPOINT_LENGTH - MAGIC_NUMBER_LENGTH);
  localparam logic [4:0] LEN_CTRLMOD = 5'(CONTROL_MODE_LENGTH - MAGIC_NUMBER_LENGTH);

  dec_state_e       r_state;
  frame_type_e      r_type;
  logic [31:0]      r_magic;
  logic [4:0]       r_idx;
  logic [4:0]       r_len;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_buf [PAYLOAD_MAX];

  logic [31:0]      w_magic_next;
  frame_type_e      w_hit_type;
  logic [4:0]       w_hit_len;
  logic             w_hit;
  logic             w_collect_byte;
  logic             w_last_byte;
  logic             w_crc_en;
  logic             w_tmo_expire;
  logic [15:0]      w_crc;
  logic [15:0]      w_rx_crc;
  logic             w_crc_ok;
  logic             w_commit;

  assign w_magic_next   = {r_magic[23:0], rx_data};
  assign w_collect_byte = rx_valid && (r_state == DEC_COLLECT);
  assign w_last_byte    = w_collect_byte && ((r_idx + 5'd1) == r_len);
  // The trailing two payload bytes are the transmitted CRC, not covered by it.
  assign w_crc_en       = w_collect_byte && (r_idx < (r_len - 5'd2));
  assign w_tmo_expire   = (r_state == DEC_COLLECT) && !rx_valid && (r_tmo == TMO_LAST);
  // Payload bytes never reach the magic matcher, so only HUNT/CHECK can hit.
  assign w_hit          = rx_valid && (r_state != DEC_COLLECT) && (w_hit_type != FRAME_NONE);
  assign w_crc_ok       = (w_crc == w_rx_crc);
  // my_id is sampled here, in CHECK, so a change mid-frame takes effect.
  assign w_commit       = (r_state == DEC_CHECK) && w_crc_ok && (r_buf[0] == my_id);

  // Classify the shift register contents including the incoming byte.
  always_comb begin
    w_hit_type = FRAME_NONE;
    w_hit_len  = '0;
    case (w_magic_next)
      MAGIC_STATUS_REQUEST: begin w_hit_type = FRAME_STATUS_REQUEST; w_hit_len = LEN_STATUS;  end
      MAGIC_SETPOINT:       begin w_hit_type = FRAME_SETPOINT;       w_hit_len = LEN_SETPNT;  end
      MAGIC_CONTROL_MODE:   begin w_hit_type = FRAME_CONTROL_MODE;   w_hit_len = LEN_CTRLMOD; end
      default:              begin w_hit_type = FRAME_NONE;           w_hit_len = '0;          end
    endcase
  end

  // Select the received CRC (last two payload bytes, high byte first).
  always_comb begin
    w_rx_crc = 16'h0000;
    case (r_type)
      FRAME_STATUS_REQUEST: w_rx_crc = {r_buf[1],  r_buf[2]};
      FRAME_SETPOINT:       w_rx_crc = {r_buf[4],  r_buf[5]};
      FRAME_CONTROL_MODE:   w_rx_crc = {r_buf[23], r_buf[24]};
      default:              w_rx_crc = 16'h0000;
    endcase
  end

  crc16_accumulator u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .i_init  (w_hit),
    .i_en    (w_crc_en),
    .i_byte  (rx_data),
    .o_crc   (w_crc)
  );

  // Decoder FSM: magic hunt, payload indexing, inter-byte timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DEC_HUNT;
      r_type  <= FRAME_NONE;
      r_magic <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_tmo   <= '0;
    end else begin
      if (rx_valid && (r_state != DEC_COLLECT))
        r_magic <= w_hit ? 32'h0 : w_magic_next;
      case (r_state)
        DEC_HUNT, DEC_CHECK: begin
          if (w_hit) begin
            r_type  <= w_hit_type;
            r_len   <= w_hit_len;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_state <= DEC_COLLECT;
          end else begin
            r_state <= DEC_HUNT;
          end
        end
        DEC_COLLECT: begin
          if (rx_valid) begin
            r_idx <= r_idx + 5'd1;
            r_tmo <= '0;
            if (w_last_byte) r_state <= DEC_CHECK;
          end else if (w_tmo_expire) begin
            r_state <= DEC_HUNT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: r_state <= DEC_HUNT;
      endcase
    end
  end

  // Payload byte store, indexed by arrival order after the magic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAYLOAD_MAX; i++) r_buf[i] <= '0;
    end else if (w_collect_byte) begin
      r_buf[r_idx] <= rx_data;
    end
  end

  // Commit validated fields and pulse the matching strobe for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_request     <= 1'b0;
      setpoint_valid     <= 1'b0;
      control_mode_valid <= 1'b0;
      setpoint           <= '0;
      control_mode       <= '0;
      Kp                 <= '0;
      Ki                 <= '0;
      Kd                 <= '0;
      PWMLimit           <= '0;
      IntegralLimit      <= '0;
      deadband           <= '0;
      gearboxRatio       <= '0;
    end else begin
      status_request     <= 1'b0;
      setpoint_valid     <= 1'b0;
      control_mode_valid <= 1'b0;
      if (w_commit) begin
        case (r_type)
          FRAME_STATUS_REQUEST: status_request <= 1'b1;
          FRAME_SETPOINT: begin
            setpoint       <= $signed({r_buf[1], r_buf[2], r_buf[3]});
            setpoint_valid <= 1'b1;
          end
          FRAME_CONTROL_MODE: begin
            control_mode       <= r_buf[1];
            Kp                 <= $signed({r_buf[2],  r_buf[3]});
            Ki                 <= $signed({r_buf[4],  r_buf[5]});
            Kd                 <= $signed({r_buf[6],  r_buf[7]});
            PWMLimit           <= $signed({r_buf[8],  r_buf[9],  r_buf[10]});
            IntegralLimit      <= $signed({r_buf[11], r_buf[12], r_buf[13]});
            deadband           <= $signed({r_buf[14], r_buf[15], r_buf[16]});
            setpoint           <= $signed({r_buf[17], r_buf[18], r_buf[19]});
            gearboxRatio       <= $signed({r_buf[20], r_buf[21], r_buf[22]});
            control_mode_valid <= 1'b1;
            setpoint_valid     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MOTOR_FRAME_DECODER_STATS_EN
  logic [15:0] r_crc_err_cnt;
  logic [15:0] r_tmo_cnt;

  // Saturating error statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc_err_cnt <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      if ((r_state == DEC_CHECK) && !w_crc_ok && (r_crc_err_cnt != 16'hFFFF))
        r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
      if (w_tmo_expire && (r_tmo_cnt != 16'hFFFF))
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign crc_error_count = r_crc_err_cnt;
  assign timeout_count   = r_tmo_cnt;
`else
  assign crc_error_count = 16'h0000;
  assign timeout_count   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motor_frame_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_motor_frame_decoder
//  Brief    : Self-checking bench for motor_frame_decoder: vector table,
//             randomized frames against a reference model, corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_frame_decoder;

`ifdef MOTOR_FRAME_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  my_id = 8'd3;
  logic        status_request, setpoint_valid, control_mode_valid;
  logic [23:0] setpoint, PWMLimit, IntegralLimit, deadband, gearboxRatio;
  logic [7:0]  control_mode;
  logic [15:0] Kp, Ki, Kd, crc_error_count, timeout_count;

  always #5 clk = ~clk;

  motor_frame_decoder dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .my_id(my_id),
    .status_request(status_request), .setpoint_valid(setpoint_valid), .setpoint(setpoint),
    .control_mode_valid(control_mode_valid), .control_mode(control_mode),
    .Kp(Kp), .Ki(Ki), .Kd(Kd), .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
    .deadband(deadband), .gearboxRatio(gearboxRatio),
    .crc_error_count(crc_error_count), .timeout_count(timeout_count)
  );

  typedef struct {
    int          kind;   // 0 status, 1 setpoint, 2 control mode
    logic [7:0]  id;
    logic [7:0]  mode;
    logic [15:0] kp, ki, kd;
    logic [23:0] pwm, il, db, sp, gear;
    bit          bad;
    int          e_st, e_sp, e_cm;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Monitor state
  int cyc = 0;
  int n_st = 0, n_sp = 0, n_cm = 0, n_cm_alone = 0;
  int last_st_cyc = -1, last_sp_cyc = -1, last_cm_cyc = -1;
  int last_byte_cyc = 0;

  // Reference model state
  logic [23:0] m_sp, m_pwm, m_il, m_db, m_gear;
  logic [15:0] m_kp, m_ki, m_kd;
  logic [7:0]  m_mode;
  int m_ce = 0, m_to = 0, e_st = 0, e_sp = 0, e_cm = 0;

  logic [7:0] fq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (status_request)     begin n_st++; last_st_cyc = cyc; end
    if (setpoint_valid)     begin n_sp++; last_sp_cyc = cyc; end
    if (control_mode_valid) begin n_cm++; last_cm_cyc = cyc; end
    if (control_mode_valid && !setpoint_valid) n_cm_alone++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sp = '0; m_pwm = '0; m_il = '0; m_db = '0; m_gear = '0;
    m_kp = '0; m_ki = '0; m_kd = '0; m_mode = '0; m_ce = 0; m_to = 0;
  endtask

  task automatic model_frame(input vec_t v, input logic [7:0] id_seen);
    if (v.bad) begin
      if (m_ce < 65535) m_ce++;
    end else if (v.id == id_seen) begin
      if (v.kind == 0) e_st++;
      else if (v.kind == 1) begin m_sp = v.sp; e_sp++; end
      else begin
        m_mode = v.mode; m_kp = v.kp; m_ki = v.ki; m_kd = v.kd;
        m_pwm = v.pwm; m_il = v.il; m_db = v.db; m_sp = v.sp; m_gear = v.gear;
        e_sp++; e_cm++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " status_cnt"}, n_st, e_st);
    chk({tag, " sp_cnt"}, n_sp, e_sp);
    chk({tag, " cm_cnt"}, n_cm, e_cm);
    chk({tag, " cm_without_sp"}, n_cm_alone, 0);
    chk({tag, " setpoint"}, {8'h0, setpoint}, {8'h0, m_sp});
    chk({tag, " mode"}, {24'h0, control_mode}, {24'h0, m_mode});
    chk({tag, " Kp"}, {16'h0, Kp}, {16'h0, m_kp});
    chk({tag, " Ki"}, {16'h0, Ki}, {16'h0, m_ki});
    chk({tag, " Kd"}, {16'h0, Kd}, {16'h0, m_kd});
    chk({tag, " PWMLimit"}, {8'h0, PWMLimit}, {8'h0, m_pwm});
    chk({tag, " IntegralLimit"}, {8'h0, IntegralLimit}, {8'h0, m_il});
    chk({tag, " deadband"}, {8'h0, deadband}, {8'h0, m_db});
    chk({tag, " gearbox"}, {8'h0, gearboxRatio}, {8'h0, m_gear});
    chk({tag, " crc_err_cnt"}, {16'h0, crc_error_count}, STATS ? m_ce : 0);
    chk({tag, " timeout_cnt"}, {16'h0, timeout_count}, STATS ? m_to : 0);
  endtask

  // CRC as polynomial remainder: (0xFFFF * x^n + M * x^16) mod (x^16+x^15+x^2+1).
  function automatic logic [15:0] crc_of(input logic [7:0] msg[$]);
    bit bits[$];
    logic [15:0] rem;
    bit top;
    foreach (msg[i]) for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
    for (int i = 0; i < 16; i++) bits.push_back(1'b0);
    for (int i = 0; i < 16; i++) bits[i] = ~bits[i];
    rem = 16'h0;
    foreach (bits[i]) begin
      top = rem[15];
      rem = {rem[14:0], bits[i]};
      if (top) rem = rem ^ 16'h8005;
    end
    return rem;
  endfunction

  task automatic build(input vec_t v);
    logic [7:0]  p[$];
    logic [15:0] c;
    logic [31:0] mg;
    p = {};
    p.push_back(v.id);
    if (v.kind == 1) begin
      p.push_back(v.sp[23:16]); p.push_back(v.sp[15:8]); p.push_back(v.sp[7:0]);
    end else if (v.kind == 2) begin
      p.push_back(v.mode);
      p.push_back(v.kp[15:8]); p.push_back(v.kp[7:0]);
      p.push_back(v.ki[15:8]); p.push_back(v.ki[7:0]);
      p.push_back(v.kd[15:8]); p.push_back(v.kd[7:0]);
      p.push_back(v.pwm[23:16]);  p.push_back(v.pwm[15:8]);  p.push_back(v.pwm[7:0]);
      p.push_back(v.il[23:16]);   p.push_back(v.il[15:8]);   p.push_back(v.il[7:0]);
      p.push_back(v.db[23:16]);   p.push_back(v.db[15:8]);   p.push_back(v.db[7:0]);
      p.push_back(v.sp[23:16]);   p.push_back(v.sp[15:8]);   p.push_back(v.sp[7:0]);
      p.push_back(v.gear[23:16]); p.push_back(v.gear[15:8]); p.push_back(v.gear[7:0]);
    end
    c = crc_of(p);
    if (v.bad) c[7:0] = ~c[7:0];
    p.push_back(c[15:8]);
    p.push_back(c[7:0]);
    mg = (v.kind == 0) ? 32'h1CE1CEBB : (v.kind == 1) ? 32'hD0D0D0D0 : 32'hBAADA555;
    fq = {};
    for (int i = 3; i >= 0; i--) fq.push_back(mg[i*8 +: 8]);
    foreach (p[i]) fq.push_back(p[i]);
  endtask

  // Called at a negedge; leaves rx_valid high for exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    last_byte_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int gapmax);
    foreach (fq[i]) begin
      send_byte(fq[i]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  function automatic vec_t mk(input int kind, input logic [7:0] id, input logic [7:0] mode,
                              input logic [15:0] kp, input logic [15:0] ki, input logic [15:0] kd,
                              input logic [23:0] pwm, input logic [23:0] il, input logic [23:0] db,
                              input logic [23:0] sp, input logic [23:0] gear, input bit b,
                              input int est, input int esp, input int ecm);
    vec_t v;
    v.kind = kind; v.id = id; v.mode = mode; v.kp = kp; v.ki = ki; v.kd = kd;
    v.pwm = pwm; v.il = il; v.db = db; v.sp = sp; v.gear = gear; v.bad = b;
    v.e_st = est; v.e_sp = esp; v.e_cm = ecm;
    return v;
  endfunction

  vec_t tbl[6];
  vec_t v;
  int s_st, s_sp, s_cm;

  initial begin
    tbl[0] = mk(0, 8'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mk(2, 8'd3, 8'd2, 16'h0100, 16'hD0D0, 16'hD0D0, 24'h0001F4, 24'h000200,
                24'h000005, 24'h000064, 24'h000032, 0, 0, 1, 1);
    tbl[2] = mk(1, 8'd3, 0, 0, 0, 0, 0, 0, 0, 24'hFFF830, 0, 0, 0, 1, 0);
    tbl[3] = mk(1, 8'd5, 0, 0, 0, 0, 0, 0, 0, 24'hFFF830, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 8'd3, 0, 0, 0, 0, 0, 0, 0, 24'h000222, 0, 1, 0, 0, 0);
    tbl[5] = mk(0, 8'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    model_reset();
    idle(5);
    compare_all("reset");
    reset_n = 1'b1;
    idle(3);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      s_st = n_st; s_sp = n_sp; s_cm = n_cm;
      build(tbl[i]);
      send_frame(0);
      idle(4);
      model_frame(tbl[i], my_id);
      chk($sformatf("tbl%0d st_delta", i), n_st - s_st, tbl[i].e_st);
      chk($sformatf("tbl%0d sp_delta", i), n_sp - s_sp, tbl[i].e_sp);
      chk($sformatf("tbl%0d cm_delta", i), n_cm - s_cm, tbl[i].e_cm);
      if (tbl[i].e_st != 0) chk($sformatf("tbl%0d st_latency", i), last_st_cyc - last_byte_cyc, 1);
      if (tbl[i].e_sp != 0) chk($sformatf("tbl%0d sp_latency", i), last_sp_cyc - last_byte_cyc, 1);
      if (tbl[i].e_cm != 0) chk($sformatf("tbl%0d cm_sp_same_cycle", i), last_cm_cyc, last_sp_cyc);
      compare_all($sformatf("tbl%0d", i));
    end
    chk("setpoint_is_minus_2000", int'($signed(setpoint)), 32'(-2000));

    // Stall after 5 bytes beyond the timeout, then a good frame
    v = mk(1, 8'd3, 0, 0, 0, 0, 0, 0, 0, 24'h123456, 0, 0, 0, 1, 0);
    build(v);
    for (int i = 0; i < 5; i++) send_byte(fq[i]);
    idle(5200);
    m_to++;
    send_frame(0);
    idle(4);
    model_frame(v, my_id);
    compare_all("timeout");

    // Long but sub-timeout gap mid-frame: frame still commits
    v = mk(1, 8'd3, 0, 0, 0, 0, 0, 0, 0, 24'h7ABCDE, 0, 0, 0, 1, 0);
    build(v);
    foreach (fq[i]) begin
      send_byte(fq[i]);
      if (i == 6) idle(4900);
    end
    idle(4);
    model_frame(v, my_id);
    compare_all("long_gap");

    // my_id changes mid-frame; CHECK uses the new value
    v = mk(1, 8'd7, 0, 0, 0, 0, 0, 0, 0, 24'h000777, 0, 0, 0, 1, 0);
    build(v);
    for (int i = 0; i < 6; i++) send_byte(fq[i]);
    my_id = 8'd7;
    for (int i = 6; i < fq.size(); i++) send_byte(fq[i]);
    idle(4);
    model_frame(v, my_id);
    compare_all("id_change");
    my_id = 8'd3;

    // Randomized frames with inter-byte gaps and filler bytes
    for (int n = 0; n < 40; n++) begin
      v.kind = $urandom_range(0, 2);
      v.id   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : my_id;
      v.mode = 8'($urandom);
      v.kp = 16'($urandom); v.ki = 16'($urandom); v.kd = 16'($urandom);
      v.pwm = 24'($urandom); v.il = 24'($urandom); v.db = 24'($urandom);
      v.sp = 24'($urandom); v.gear = 24'($urandom);
      v.bad = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 3)) begin
        send_byte(8'($urandom_range(0, 15)));
        idle($urandom_range(0, 2));
      end
      build(v);
      send_frame(2);
      idle(4);
      model_frame(v, my_id);
      compare_all($sformatf("rand%0d", n));
    end

    // Reset in the middle of a control-mode frame
    v = mk(2, 8'd3, 8'd9, 16'h1111, 16'h2222, 16'h3333, 24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 0, 0, 1, 1);
    build(v);
    for (int i = 0; i < 12; i++) send_byte(fq[i]);
    reset_n = 1'b0;
    idle(2);
    model_reset();
    compare_all("mid_reset");
    reset_n = 1'b1;
    idle(2);
    v = mk(0, 8'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    build(v);
    send_frame(0);
    idle(4);
    model_frame(v, my_id);
    compare_all("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_frame_decoder.md
# motor_frame_decoder

Motor-board-side receive decoder for the RS485 motor bus. It sits directly downstream of the board's UART byte receiver and consumes the byte stream that the FPGA bus master transmits. It hunts for the three master frame types, accumulates CRC16, and filters on the board's motor ID. Validated fields are presented to the local motor controller as registered outputs with one-cycle update strobes.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
- `BAUDRATE`, default 2_000_000: bus baud rate, used for the inter-byte timeout.
- `TIMEOUT_BYTES`, default 20: inter-byte gap, in byte times, that aborts a frame.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `my_id` in 8: this board's motor ID; quasi-static.
- `status_request` out 1: one-cycle pulse when a valid status-request frame for `my_id` is received.
- `setpoint_valid` out 1: one-cycle pulse when `setpoint` is updated.
- `setpoint` out 24 signed: commanded setpoint.
- `control_mode_valid` out 1: one-cycle pulse when the control-mode parameter set is updated.
- `control_mode` out 8: control mode.
- `Kp`, `Ki`, `Kd` out 16 signed each: controller gains.
- `PWMLimit`, `IntegralLimit`, `deadband`, `gearboxRatio` out 24 signed each: controller limits and gearbox ratio.
- `crc_error_count` out 16: count of frames with a bad CRC.
- `timeout_count` out 16: count of frames aborted by timeout.

## Operation
- Frames are big-endian. CRC16 uses polynomial x^16+x^15+x^2+1, init 0xFFFF, first serial bit D[7]. CRC covers the bytes after the magic number, excluding the CRC bytes. CRC is sent high byte first.
- Status request: magic 0x1CE1CEBB, then id, crc[2]. Total length 7.
- Setpoint: magic 0xD0D0D0D0, then id, setpoint[3], crc[2]. Total length 10.
- Control mode: magic 0xBAADA555, then id, mode, Kp[2], Ki[2], Kd[2], PWMLimit[3], IntegralLimit[3], deadband[3], setpoint[3], gearboxRatio[3], crc[2]. Total length 29.
- State machine:
  - HUNT: a 4-byte shift register shifts on each `rx_valid`. When it matches one of the three magic numbers, latch the frame type, set the expected payload length (total length minus 4), clear the shift register, load CRC with 0xFFFF, clear the byte index, and go to COLLECT.
  - COLLECT: on each `rx_valid`, store the byte at the index and increment the index. Fold the byte into the CRC if it is not one of the last two bytes. When index reaches the payload length, go to CHECK. If no byte arrives for `CLK_FREQ_HZ/BAUDRATE*10*TIMEOUT_BYTES` cycles, go to HUNT and increment `timeout_count`.
  - CHECK (1 cycle): compare the accumulated CRC against the last two payload bytes.
    - Mismatch: increment `crc_error_count`.
    - Match and id == `my_id`: commit the fields and pulse the frame's strobe.
    - Match and id != `my_id`: drop silently.
    - Always return to HUNT.
- Control-mode commit also updates `setpoint` and pulses `setpoint_valid` together with `control_mode_valid`.
- Both counters saturate at 0xFFFF; they do not wrap.
- Payload bytes never feed the magic shift register, so magic-like bytes inside a frame are ignored.
- `rx_valid` arriving during CHECK is shifted into the magic register; no byte is lost.

## Timing
- Reset values: every output is 0, the state is HUNT, and all internal registers are 0.
- Latency: if the final CRC byte's `rx_valid` is at cycle N, CHECK is at N+1. Fields and strobe are visible at N+2, and the strobe is high for exactly one cycle.
- Field outputs hold their values until the next committed frame of the same type.
- Timeout counter reloads on every `rx_valid` in COLLECT.
- Asserting `reset_n` low mid-frame aborts the frame immediately. Counters are not incremented.
- A `my_id` change mid-frame is sampled at CHECK.

## Configuration
- `MOTOR_FRAME_DECODER_STATS_EN`
  - Defined: `crc_error_count` and `timeout_count` are implemented as specified.
  - Undefined: both ports are tied to 0, no counter flops are built, and decode behaviour is otherwise identical.

## Structure
- Package `motor_frame_pkg` holds:
  - the magic-number localparams;
  - the frame lengths (7/10/29, MAGIC_NUMBER_LENGTH=4, MAX_FRAME_LENGTH=29);
  - the frame-type enum and the decoder state enum;
  - the `nextCRC16_D8` function.
- One sub-module, `crc16_accumulator`: registered 16-bit CRC with `init` and `en`+`byte` inputs, used by COLLECT.

## Test plan
- my_id=3; valid status request for id 3 -> `status_request` pulses once at N+2; all other outputs unchanged.
- Valid setpoint frame, id 3, setpoint 0xFFF830 -> `setpoint`=-2000, `setpoint_valid` one pulse; the same frame with id 5 -> no pulse, counters stay 0.
- Control-mode frame with mode 2, Kp 0x0100, PWMLimit 0x0001F4, setpoint 0x000064 -> all fields latched; `control_mode_valid` and `setpoint_valid` pulse in the same cycle.
- Setpoint frame with the CRC low byte flipped -> no strobe, `setpoint` unchanged, `crc_error_count`=1.
- Setpoint frame stalled after 5 bytes for longer than the timeout, then a valid setpoint frame -> `timeout_count`=1 and the second frame commits.
- Control-mode frame whose payload contains 0xD0D0D0D0 -> decodes as control mode with no setpoint-frame false start; reset asserted mid-frame -> all outputs 0 and state HUNT.
